// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM port arbiter.
// FSM encoding and the registered port bundle.
package sdram_arb_pkg;

    localparam int AW = 24;
    localparam int DW = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_GAP   = 2'd3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rd;
        logic          wrl;
        logic          wrh;
        logic [DW-1:0] din;
    } port_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Searches from ptr upward and wraps; returns a one-hot grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW:0] k;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = {1'b0, ptr} + (PW+1)'(i);
            if (k >= (PW+1)'(N))
                k = k - (PW+1)'(N);
            if (!found && req[k[PW-1:0]]) begin
                gnt[k[PW-1:0]] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares one SDRAM controller port between N_REQ
// requesters, turning level req/ack into edge strobes with a low gap.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 24,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   we,
    input  logic [2*N_REQ-1:0] be,
    input  logic [AW*N_REQ-1:0] addr,
    input  logic [DW*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   ack,
    output logic [DW-1:0]      rdata,
    output logic [N_REQ-1:0]   grant,
    output logic [AW-1:0]      p_addr,
    output logic               p_rd,
    output logic               p_wrl,
    output logic               p_wrh,
    output logic [DW-1:0]      p_din,
    input  logic [DW-1:0]      p_dout,
    input  logic               p_busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    port_t            p_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ack_q;
    logic [DW-1:0]    rdata_q;
    logic [PW-1:0]    ptr;

    logic [N_REQ-1:0] win;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr_nxt;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_din;
    logic             sel_we;
    logic [1:0]       sel_be;
    logic             sel_nop;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (win)
    );

    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        sel_be   = '0;
        win_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                sel_addr = addr[i*AW +: AW];
                sel_din  = wdata[i*DW +: DW];
                sel_we   = we[i];
                sel_be   = be[2*i +: 2];
                win_idx  = PW'(i);
            end
        end
    end

    assign ptr_nxt = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
    // A write with no byte lanes never touches the port.
    assign sel_nop = sel_we && (sel_be == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            p_q     <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            ptr     <= '0;
        end else begin
            ack_q <= '0;
            unique case (state)
                S_IDLE: begin
                    if (|req && !p_busy) begin
                        grant_q  <= win;
                        ptr      <= ptr_nxt;
                        p_q.addr <= sel_addr;
                        p_q.din  <= sel_din;
                        p_q.rd   <= !sel_we;
                        p_q.wrl  <= sel_we & sel_be[0];
                        p_q.wrh  <= sel_we & sel_be[1];
                        state    <= sel_nop ? S_WAIT : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (p_busy)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!p_busy) begin
                        p_q.rd  <= 1'b0;
                        p_q.wrl <= 1'b0;
                        p_q.wrh <= 1'b0;
                        if (p_q.rd)
                            rdata_q <= p_dout;
                        ack_q   <= grant_q;
                        grant_q <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign grant  = grant_q;
    assign rdata  = rdata_q;
    assign p_addr = p_q.addr;
    assign p_rd   = p_q.rd;
    assign p_wrl  = p_q.wrl;
    assign p_wrh  = p_q.wrh;
    assign p_din  = p_q.din;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: scoreboard bench with a behavioural SDRAM port.
// Expected port ops and acks are queued as requests are raised.
module tb_sdram_port_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   we = '0;
    logic [7:0]   be = '0;
    logic [95:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic [3:0]   ack;
    logic [15:0]  rdata;
    logic [3:0]   grant;
    logic [23:0]  p_addr;
    logic         p_rd;
    logic         p_wrl;
    logic         p_wrh;
    logic [15:0]  p_din;
    logic [15:0]  p_dout = '0;
    logic         p_busy = 1'b0;

    sdram_port_arb #(
        .N_REQ (4),
        .AW    (24),
        .DW    (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .grant  (grant),
        .p_addr (p_addr),
        .p_rd   (p_rd),
        .p_wrl  (p_wrl),
        .p_wrh  (p_wrh),
        .p_din  (p_din),
        .p_dout (p_dout),
        .p_busy (p_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_val(input logic [23:0] a);
        return (a == 24'h000100) ? 16'hA55A : (a[15:0] ^ 16'h5A5A);
    endfunction

    // SDRAM port model: busy rises one cycle after a strobe edge
    int          busy_len = 4;
    int          bcnt = 0;
    logic        stb_q = 1'b0;

    always @(posedge clk) begin
        stb_q <= p_rd | p_wrl | p_wrh;
        if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1)
                p_busy <= 1'b0;
        end else if ((p_rd | p_wrl | p_wrh) && !stb_q) begin
            bcnt   <= busy_len;
            p_busy <= 1'b1;
            if (p_rd)
                p_dout <= rd_val(p_addr);
        end
    end

    typedef struct {
        int          idx;
        bit          rd;
        bit          zw;
        logic [15:0] data;
    } ack_t;

    typedef struct {
        logic [23:0] a;
        bit          rd;
        bit          wl;
        bit          wh;
        logic [15:0] d;
    } prt_t;

    ack_t exp_ack[$];
    prt_t exp_port[$];

    task automatic push_exp(input int i, input bit w, input logic [1:0] b,
                            input logic [23:0] a, input logic [15:0] d);
        ack_t e;
        prt_t p;
        e.idx  = i;
        e.rd   = !w;
        e.zw   = w && (b == 2'b00);
        e.data = w ? 16'h0 : rd_val(a);
        exp_ack.push_back(e);
        if (!e.zw) begin
            p.a  = a;
            p.rd = !w;
            p.wl = w & b[0];
            p.wh = w & b[1];
            p.d  = d;
            exp_port.push_back(p);
        end
    endtask

    task automatic set_req(input int i, input bit w, input logic [1:0] b,
                           input logic [23:0] a, input logic [15:0] d);
        we[i]          = w;
        be[2*i +: 2]   = b;
        addr[24*i +: 24] = a;
        wdata[16*i +: 16] = d;
        req[i]         = 1'b1;
    endtask

    task automatic issue(input int i, input bit w, input logic [1:0] b,
                         input logic [23:0] a, input logic [15:0] d);
        push_exp(i, w, b, a, d);
        set_req(i, w, b, a, d);
    endtask

    // Monitor: port edges, grant rises, busy falls and acks
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   fall_cyc = 0;
    int   last_ack = -100;
    int   port_cnt = 0;
    int   ack_cnt [4] = '{0, 0, 0, 0};
    bit   chk_gap = 1'b0;
    logic stb_m = 1'b0;
    logic stb_n;
    logic [3:0] grant_m = '0;
    logic busy_m = 1'b0;
    logic [3:0] ev;
    ack_t ae;
    prt_t pe;

    always @(negedge clk) begin
        cyc++;
        stb_n = p_rd | p_wrl | p_wrh;
        if (stb_n && !stb_m) begin
            port_cnt++;
            if (exp_port.size() == 0) begin
                chk("port_unexp", 64'(1), 64'(0));
            end else begin
                pe = exp_port.pop_front();
                chk("p_addr", 64'(p_addr), 64'(pe.a));
                chk("p_strb", 64'({p_rd, p_wrh, p_wrl}),
                    64'({pe.rd, pe.wh, pe.wl}));
                if (!pe.rd)
                    chk("p_din", 64'(p_din), 64'(pe.d));
            end
        end
        if (grant != 4'b0 && grant_m == 4'b0) begin
            gnt_cyc = cyc;
            chk("gnt_onehot", 64'($onehot(grant)), 64'(1));
        end
        if (busy_m && !p_busy)
            fall_cyc = cyc;
        if (ack != 4'b0) begin
            if (exp_ack.size() == 0) begin
                chk("ack_unexp", 64'(ack), 64'(0));
            end else begin
                ae = exp_ack.pop_front();
                ev = 4'(1 << ae.idx);
                chk("ack_vec", 64'(ack), 64'(ev));
                if (ae.rd)
                    chk("rdata", 64'(rdata), 64'(ae.data));
                if (ae.zw)
                    chk("zw_lat", 64'(cyc - gnt_cyc), 64'(1));
                else
                    chk("ack_lat", 64'(cyc - fall_cyc), 64'(1));
                if (chk_gap)
                    chk("ack_gap_ge4", 64'(cyc - last_ack >= 4), 64'(1));
                ack_cnt[ae.idx]++;
            end
            last_ack = cyc;
        end
        stb_m   = stb_n;
        grant_m = grant;
        busy_m  = p_busy;
    end

    task automatic wait_ack(input int i, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < budget);
        chk($sformatf("ack%0d_seen", i), 64'(ack[i]), 64'(1));
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!p_busy && n < budget);
        chk("busy_seen", 64'(p_busy), 64'(1));
    endtask

    initial begin
        int pc;
        int n;
        bit bad;

        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_strb", 64'({p_rd, p_wrl, p_wrh}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_addr", 64'(p_addr), 64'(0));
        chk("rst_din", 64'(p_din), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single read, 6 busy cycles
        busy_len = 6;
        issue(0, 1'b0, 2'b00, 24'h000100, 16'h0000);
        wait_ack(0, 60);
        req[0] = 1'b0;
        repeat (5) @(negedge clk);

        // high-byte write
        busy_len = 3;
        issue(1, 1'b1, 2'b10, 24'h000200, 16'h1234);
        wait_ack(1, 60);
        req[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("ack1_once", 64'(ack_cnt[1]), 64'(1));

        // write with no byte lanes
        pc = port_cnt;
        issue(2, 1'b1, 2'b00, 24'h000300, 16'hBEEF);
        wait_ack(2, 20);
        req[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("zw_noport", 64'(port_cnt), 64'(pc));

        // req[3] dropped mid-access, then full contention
        chk_gap  = 1'b1;
        busy_len = 8;
        issue(3, 1'b0, 2'b00, 24'h000400, 16'h0000);
        wait_busy(30);
        req[3]   = 1'b0;
        busy_len = 2;
        issue(0, 1'b0, 2'b00, 24'h001000, 16'h0000);
        issue(1, 1'b0, 2'b00, 24'h001001, 16'h0000);
        issue(2, 1'b0, 2'b00, 24'h001002, 16'h0000);
        wait_ack(3, 60);
        issue(3, 1'b0, 2'b00, 24'h001003, 16'h0000);
        push_exp(0, 1'b0, 2'b00, 24'h001000, 16'h0000);
        wait_ack(0, 60);
        wait_ack(1, 60);
        wait_ack(2, 60);
        wait_ack(3, 60);
        wait_ack(0, 60);
        req     = '0;
        chk_gap = 1'b0;
        repeat (6) @(negedge clk);

        // reset during WAIT, released while busy still high
        busy_len = 10;
        issue(0, 1'b0, 2'b00, 24'h000500, 16'h0000);
        wait_busy(30);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 64'(grant), 64'(0));
        chk("mid_rst_strb", 64'({p_rd, p_wrl, p_wrh}), 64'(0));
        chk("mid_rst_ack", 64'(ack), 64'(0));
        exp_ack.delete();
        exp_port.delete();
        repeat (2) @(negedge clk);
        chk("busy_at_rel", 64'(p_busy), 64'(1));
        push_exp(0, 1'b0, 2'b00, 24'h000500, 16'h0000);
        rst_n = 1'b1;
        bad = 1'b0;
        n = 0;
        do begin
            if (grant != 4'b0)
                bad = 1'b1;
            @(negedge clk);
            n++;
        end while (p_busy && n < 40);
        chk("no_gnt_busy", 64'(bad), 64'(0));
        wait_ack(0, 60);
        req[0] = 1'b0;
        repeat (6) @(negedge clk);

        chk("port_q_left", 64'(exp_port.size()), 64'(0));
        chk("ack_q_left", 64'(exp_ack.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
